// File: rtl/mem_subword_unit_pkg.sv
// Shared definitions for the sub-word load/store sequencer: op codes, FSM states
// and the small lane/alignment helpers used by the top and the lane datapath.
package mem_subword_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Physical byte lane inside the memory word; big-endian mirrors the lanes.
    function automatic logic [1:0] lane_index(input logic [1:0] addr_lo, input logic big_endian);
        return addr_lo ^ {2{big_endian}};
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_subword_store(input op_e op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_subword_unit_if.sv
// Request/response and memory-port bundle of the sub-word load/store sequencer.
// The slave side is the sequencer; the master side is datapath plus memory.
interface mem_subword_unit_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output start, op, addr, wdata, mem_rdata,
        input  busy, done, rdata, misaligned, mem_addr, mem_wr, mem_wdata
    );

    modport slave (
        input  start, op, addr, wdata, mem_rdata,
        output busy, done, rdata, misaligned, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_subword_unit_lane.sv
// Combinational lane datapath: extracts and extends load data from a memory word,
// and merges store data into the selected byte/half lane of that word.
module mem_subword_unit_lane
    import mem_subword_unit_pkg::*;
(
    input  op_e         i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // i_lane is already the physical byte lane; a halfword lives in lane pair i_lane[1].
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'd0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'd0, w_half};
            default: o_load = i_word;
        endcase

        o_store = i_word;
        case (i_op)
            OP_SB: begin
                case (i_lane)
                    2'd0:    o_store[7:0]   = i_wdata[7:0];
                    2'd1:    o_store[15:8]  = i_wdata[7:0];
                    2'd2:    o_store[23:16] = i_wdata[7:0];
                    default: o_store[31:24] = i_wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (i_lane[1]) o_store[31:16] = i_wdata[15:0];
                else           o_store[15:0]  = i_wdata[15:0];
            end
            default: o_store = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_subword_unit.sv
// Multicycle load/store sequencer between the datapath and a word-wide synchronous
// memory: lane select, load extension, read-modify-write sub-word stores.
module mem_subword_unit
    import mem_subword_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_subword_unit_if.slave bus
);
    localparam logic       BE     = (BIG_ENDIAN != 0);
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_e            r_state;
    logic [1:0]        r_cnt;
    op_e               r_op;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_misaligned;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wr;
    logic [31:0]       r_mem_wdata;

    op_e               w_op;
    logic              w_mis;
    logic [1:0]        w_lane;
    logic [31:0]       w_load;
    logic [31:0]       w_store;

    assign w_op   = op_e'(bus.op);
    assign w_mis  = is_misaligned(w_op, bus.addr[1:0]);
    assign w_lane = lane_index(r_addr_lo, BE);

    mem_subword_unit_lane u_lane (
        .i_op    (r_op),
        .i_lane  (w_lane),
        .i_word  (bus.mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_store (w_store)
    );

    // Request fields are only consumed after an accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start) begin
            r_op      <= w_op;
            r_addr_lo <= bus.addr[1:0];
            r_wdata   <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_mem_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy       <= 1'b1;
                        r_mem_addr   <= {bus.addr[ADDR_W-1:2], 2'b00};
                        r_misaligned <= w_mis;
                        if (w_mis) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_op == OP_SW) begin
                            r_state     <= S_WRITE;
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= bus.wdata;
                        end else begin
                            r_state <= S_READ;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                // Memory word is valid on the last READ edge; consume it directly from the port.
                S_READ: begin
                    if (r_cnt == 2'd0) begin
                        if (is_subword_store(r_op)) begin
                            r_state     <= S_WRITE;
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= w_store;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rdata      = r_rdata;
    assign bus.misaligned = r_misaligned;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Bench for mem_subword_unit: a little-endian MEM_LAT=1 instance and a big-endian
// MEM_LAT=3 instance, each with its own word memory, sharing one request driver.
module tb_mem_subword_unit;
    import mem_subword_unit_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_subword_unit_if #(.ADDR_W(32)) if_a ();
    mem_subword_unit_if #(.ADDR_W(32)) if_b ();

    mem_subword_unit #(.ADDR_W(32), .MEM_LAT(LAT_A), .BIG_ENDIAN(0)) u_dut_a (
        .clk (clk), .reset (reset), .bus (if_a)
    );
    mem_subword_unit #(.ADDR_W(32), .MEM_LAT(LAT_B), .BIG_ENDIAN(1)) u_dut_b (
        .clk (clk), .reset (reset), .bus (if_b)
    );

    // shared request driver, gated per instance
    bit          tb_sel = 1'b0;
    logic        tb_start = 1'b0;
    logic [2:0]  tb_op = 3'd0;
    logic [31:0] tb_addr = 32'd0;
    logic [31:0] tb_wdata = 32'd0;

    assign if_a.start = tb_start && !tb_sel;
    assign if_b.start = tb_start && tb_sel;
    assign if_a.op = tb_op;
    assign if_b.op = tb_op;
    assign if_a.addr = tb_addr;
    assign if_b.addr = tb_addr;
    assign if_a.wdata = tb_wdata;
    assign if_b.wdata = tb_wdata;

    // word memories with preload port
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rp_b0, rp_b1;
    bit          pl_en = 1'b0;
    bit          pl_sel = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_idx] <= pl_val;
        else if (if_a.mem_wr) mem_a[if_a.mem_addr[9:2]] <= if_a.mem_wdata;
    end
    assign if_a.mem_rdata = mem_a[if_a.mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en && pl_sel) mem_b[pl_idx] <= pl_val;
        else if (if_b.mem_wr) mem_b[if_b.mem_addr[9:2]] <= if_b.mem_wdata;
        rp_b0 <= mem_b[if_b.mem_addr[9:2]];
        rp_b1 <= rp_b0;
    end
    assign if_b.mem_rdata = rp_b1;

    logic        o_busy, o_done, o_mis, o_wr;
    logic [31:0] o_rdata, o_wdata, o_maddr;
    always_comb begin
        o_busy  = tb_sel ? if_b.busy       : if_a.busy;
        o_done  = tb_sel ? if_b.done       : if_a.done;
        o_mis   = tb_sel ? if_b.misaligned : if_a.misaligned;
        o_wr    = tb_sel ? if_b.mem_wr     : if_a.mem_wr;
        o_rdata = tb_sel ? if_b.rdata      : if_a.rdata;
        o_wdata = tb_sel ? if_b.mem_wdata  : if_a.mem_wdata;
        o_maddr = tb_sel ? if_b.mem_addr   : if_a.mem_addr;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] last_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input bit s, input logic [7:0] idx, input logic [31:0] val);
        pl_sel = s; pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Reference: bytes in address order, lanes derived from endianness.
    function automatic void model(input bit be, input int lat_cfg, input logic [2:0] op,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] word, output logic mis, output bit is_ld,
                                  output logic [31:0] ld, output logic [31:0] nw,
                                  output int elat);
        logic [7:0]  b [4];
        logic [15:0] h;
        int a;
        a = int'(addr[1:0]);
        for (int k = 0; k < 4; k++) b[k] = be ? word[8*(3-k) +: 8] : word[8*k +: 8];
        is_ld = (op <= 3'd4);
        case (op)
            3'd0, 3'd5:       mis = (a != 0);
            3'd1, 3'd2, 3'd6: mis = (a % 2 != 0);
            default:          mis = 1'b0;
        endcase
        ld = word;
        nw = word;
        h = 16'h0;
        if (!mis) begin
            case (op)
                3'd1, 3'd2: begin
                    h  = be ? {b[a], b[a+1]} : {b[a+1], b[a]};
                    ld = (op == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
                end
                3'd3: ld = {{24{b[a][7]}}, b[a]};
                3'd4: ld = {24'h0, b[a]};
                3'd5: nw = wd;
                3'd6: begin
                    if (be) begin b[a] = wd[15:8]; b[a+1] = wd[7:0]; end
                    else    begin b[a] = wd[7:0];  b[a+1] = wd[15:8]; end
                end
                3'd7: b[a] = wd[7:0];
                default: ;
            endcase
            if (op == 3'd6 || op == 3'd7)
                for (int k = 0; k < 4; k++)
                    if (be) nw[8*(3-k) +: 8] = b[k];
                    else    nw[8*k +: 8]     = b[k];
        end
        elat = mis ? 1 : (op <= 3'd4) ? lat_cfg + 1 : (op == 3'd5) ? 2 : lat_cfg + 2;
    endfunction

    // Runs one request from an IDLE cycle and returns in the following IDLE cycle.
    task automatic do_txn(input string tag, input bit s, input bit pre, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] word, input logic [31:0] exp_rd,
                          input int exp_lat, input logic exp_mis, input logic [31:0] exp_word);
        int lat, nwr, nlow;
        bit got;
        logic [31:0] wdat, waddr, memw;
        logic exp_nwr;
        if (pre) preload(s, addr[9:2], word);
        tb_sel = s; tb_op = op; tb_addr = addr; tb_wdata = wd; tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        lat = 1; nwr = 0; nlow = 0; got = 1'b0; wdat = '0; waddr = '0;
        while (1) begin
            if (o_wr) begin nwr++; wdat = o_wdata; waddr = o_maddr; end
            if (!o_busy) nlow++;
            if (o_done) begin got = 1'b1; break; end
            if (lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(nlow), 32'd0);
        chk({tag, "_mis"}, 32'(o_mis), 32'(exp_mis));
        chk({tag, "_rdata"}, o_rdata, exp_rd);
        exp_nwr = (op >= 3'd5) && !exp_mis;
        chk({tag, "_nwr"}, 32'(nwr), 32'(exp_nwr));
        if (exp_nwr) begin
            chk({tag, "_waddr"}, waddr, {addr[31:2], 2'b00});
            chk({tag, "_wdata"}, wdat, exp_word);
        end
        memw = s ? mem_b[addr[9:2]] : mem_a[addr[9:2]];
        chk({tag, "_mem"}, memw, exp_word);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, o_busy, o_done}, 32'd0);
        chk({tag, "_mishold"}, 32'(o_mis), 32'(exp_mis));
    endtask

    typedef struct {
        bit          s;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        logic [31:0] rd;
        int          lat;
        logic        mis;
        logic [31:0] nword;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_mis;
        bit          r_ld;
        logic [31:0] r_ldv, r_nw, r_word, r_wd, r_addr;
        logic [2:0]  r_op;
        int          r_lat, n;
        bit          s;

        tbl[0]  = '{1'b0, OP_LB,  32'h1003, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 2, 1'b0, 32'h80FF1234};
        tbl[1]  = '{1'b0, OP_LBU, 32'h1003, 32'h0,        32'h80FF1234, 32'h00000080, 2, 1'b0, 32'h80FF1234};
        tbl[2]  = '{1'b0, OP_SH,  32'h2002, 32'hAAAABEEF, 32'h11223344, 32'h00000080, 3, 1'b0, 32'hBEEF3344};
        tbl[3]  = '{1'b1, OP_SB,  32'h2001, 32'h00000055, 32'h11223344, 32'h00000000, 5, 1'b0, 32'h11553344};
        tbl[4]  = '{1'b0, OP_LW,  32'h3002, 32'h0,        32'hCAFEF00D, 32'h00000080, 1, 1'b1, 32'hCAFEF00D};
        tbl[5]  = '{1'b0, OP_LH,  32'h1002, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 2, 1'b0, 32'h80FF1234};
        tbl[6]  = '{1'b1, OP_LHU, 32'h1000, 32'h0,        32'h80FF1234, 32'h000080FF, 4, 1'b0, 32'h80FF1234};
        tbl[7]  = '{1'b0, OP_SW,  32'h4000, 32'h12345678, 32'h00000000, 32'hFFFF80FF, 2, 1'b0, 32'h12345678};
        tbl[8]  = '{1'b1, OP_LB,  32'h1001, 32'h0,        32'h80FF1234, 32'hFFFFFFFF, 4, 1'b0, 32'h80FF1234};
        tbl[9]  = '{1'b0, OP_SH,  32'h2001, 32'h0000BEEF, 32'h11223344, 32'hFFFF80FF, 1, 1'b1, 32'h11223344};
        tbl[10] = '{1'b1, OP_LW,  32'h5004, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF};
        tbl[11] = '{1'b0, OP_LH,  32'h1001, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 1, 1'b1, 32'h80FF1234};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ctl", {28'd0, if_a.busy, if_a.done, if_a.misaligned, if_a.mem_wr}, 32'd0);
        chk("rst_a_rdata", if_a.rdata, 32'd0);
        chk("rst_a_maddr", if_a.mem_addr, 32'd0);
        chk("rst_a_mwdata", if_a.mem_wdata, 32'd0);
        chk("rst_b_ctl", {28'd0, if_b.busy, if_b.done, if_b.misaligned, if_b.mem_wr}, 32'd0);
        chk("rst_b_rdata", if_b.rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ctl", {28'd0, if_a.busy, if_a.done, if_b.busy, if_b.done}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("tbl%0d", i), tbl[i].s, 1'b1, tbl[i].op, tbl[i].addr, tbl[i].wd,
                   tbl[i].word, tbl[i].rd, tbl[i].lat, tbl[i].mis, tbl[i].nword);
            last_rd[tbl[i].s] = tbl[i].rd;
        end

        // back-to-back: second request in the IDLE cycle right after DONE
        do_txn("b2b0", 1'b0, 1'b1, OP_LW,  32'h1000, 32'h0, 32'h80FF1234, 32'h80FF1234, 2, 1'b0, 32'h80FF1234);
        do_txn("b2b1", 1'b0, 1'b0, OP_LBU, 32'h1001, 32'h0, 32'h80FF1234, 32'h00000012, 2, 1'b0, 32'h80FF1234);
        last_rd[0] = 32'h00000012;

        for (int i = 0; i < 150; i++) begin
            s      = 1'($urandom_range(0, 1));
            r_op   = 3'($urandom_range(0, 7));
            r_addr = $urandom & 32'h0000_03FF;
            r_wd   = $urandom;
            r_word = $urandom;
            model(s, s ? LAT_B : LAT_A, r_op, r_addr, r_wd, r_word, r_mis, r_ld, r_ldv, r_nw, r_lat);
            if (r_ld && !r_mis) last_rd[s] = r_ldv;
            do_txn($sformatf("rnd%0d", i), s, 1'b1, r_op, r_addr, r_wd, r_word, last_rd[s],
                   r_lat, r_mis, r_nw);
        end

        // reset during READ of an SB: no write, clean restart
        preload(1'b0, 8'd0, 32'h11223344);
        tb_sel = 1'b0; tb_op = OP_SB; tb_addr = 32'h2001; tb_wdata = 32'h77; tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        chk("t6a_in_read", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6a_ctl", {28'd0, o_busy, o_done, o_mis, o_wr}, 32'd0);
        chk("t6a_rdata", o_rdata, 32'd0);
        chk("t6a_maddr", o_maddr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6a_mem", mem_a[0], 32'h11223344);
        do_txn("t6a_lw", 1'b0, 1'b0, OP_LW, 32'h2000, 32'h0, 32'h11223344, 32'h11223344, 2, 1'b0, 32'h11223344);

        // reset during the WRITE cycle: write enable drops before the edge
        preload(1'b1, 8'd0, 32'hA5A5A5A5);
        tb_sel = 1'b1; tb_op = OP_SB; tb_addr = 32'h2003; tb_wdata = 32'h3C; tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        n = 0;
        while (!o_wr && n < 10) begin @(posedge clk); #1; n++; end
        chk("t6b_wr_seen", 32'(o_wr), 32'd1);
        chk("t6b_wr_cycle", 32'(n), 32'(LAT_B));
        reset = 1'b1;
        #1;
        chk("t6b_wr_async", 32'(o_wr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6b_mem", mem_b[0], 32'hA5A5A5A5);
        @(posedge clk); #1;
        do_txn("t6b_lbu", 1'b1, 1'b0, OP_LBU, 32'h2003, 32'h0, 32'hA5A5A5A5, 32'h000000A5, 4, 1'b0, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
